// File: rtl/f2_sprite_pkg.sv
// Shared types for the sprite RAM scanner: descriptor layout, scan FSM states
// and the index of each 16-bit word inside a sprite RAM entry.
package f2_sprite_pkg;

    localparam int CODE_IN_W  = 14;
    localparam int CODE_OUT_W = 20;
    localparam int POS_W      = 12;

    localparam logic [1:0] WORD_CODE = 2'd0;
    localparam logic [1:0] WORD_X    = 2'd1;
    localparam logic [1:0] WORD_Y    = 2'd2;
    localparam logic [1:0] WORD_ATTR = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        BANK,
        CAPT,
        PUSH,
        DONE
    } scan_state_t;

    typedef struct packed {
        logic [CODE_OUT_W-1:0] code;
        logic [POS_W-1:0]      x;
        logic [POS_W-1:0]      y;
        logic [7:0]            color;
        logic                  flipx;
        logic                  flipy;
    } sprite_desc_t;

endpackage

// File: rtl/f2_sprite_scan_if.sv
// Bus bundle of the sprite scanner: sprite RAM read port, code-banking
// request/response and the descriptor valid/ready stream.
interface f2_sprite_scan_if;
    import f2_sprite_pkg::*;

    logic                  ram_rd;
    logic [11:0]           ram_addr;
    logic [15:0]           ram_data;
    logic                  code_req;
    logic [CODE_IN_W-1:0]  code_original;
    logic [CODE_OUT_W-1:0] code_modified;
    logic                  desc_valid;
    logic                  desc_ready;
    logic [CODE_OUT_W-1:0] desc_code;
    logic [POS_W-1:0]      desc_x;
    logic [POS_W-1:0]      desc_y;
    logic [7:0]            desc_color;
    logic                  desc_flipx;
    logic                  desc_flipy;

    modport master (
        output ram_rd, ram_addr, code_req, code_original,
        output desc_valid, desc_code, desc_x, desc_y, desc_color, desc_flipx, desc_flipy,
        input  ram_data, code_modified, desc_ready
    );

    modport slave (
        input  ram_rd, ram_addr, code_req, code_original,
        input  desc_valid, desc_code, desc_x, desc_y, desc_color, desc_flipx, desc_flipy,
        output ram_data, code_modified, desc_ready
    );

endinterface

// File: rtl/f2_sprite_desc_fifo.sv
// First-word-fall-through descriptor FIFO; a write into a full FIFO is refused
// even when a read happens in the same cycle.
module f2_sprite_desc_fifo
    import f2_sprite_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  sprite_desc_t wr_data,
    output logic         full,
    input  logic         rd_en,
    output sprite_desc_t rd_data,
    output logic         empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    sprite_desc_t  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_wr;
    logic          do_rd;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/f2_sprite_scan.sv
// Walks sprite RAM, banks each tile code and queues sprite descriptors.
// Define F2_SPRITE_EMPTY_SKIP_EN to skip entries whose code word is zero.
module f2_sprite_scan
    import f2_sprite_pkg::*;
#(
    parameter int NUM_ENTRIES = 1024,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    f2_sprite_scan_if.master    bus
);

`ifdef F2_SPRITE_EMPTY_SKIP_EN
    localparam bit SKIP_EMPTY = 1'b1;
`else
    localparam bit SKIP_EMPTY = 1'b0;
`endif

    localparam logic [9:0] LAST_ENTRY = 10'(NUM_ENTRIES - 1);

    scan_state_t          state;
    logic [9:0]           entry;
    logic [1:0]           word;
    logic                 rd_q;
    logic [1:0]           word_q;
    logic [CODE_IN_W-1:0] w_code;
    logic [POS_W-1:0]     w_x;
    logic [POS_W-1:0]     w_y;
    logic [9:0]           w_attr;
    sprite_desc_t         desc_reg;
    sprite_desc_t         head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_wr;
    logic                 entry_empty;
    logic                 unused_bits;

    assign bus.ram_addr = {entry, word};
    assign fifo_wr      = (state == PUSH) && !fifo_full;
    assign entry_empty  = SKIP_EMPTY && (w_code == '0);
    assign unused_bits  = ^bus.ram_data[15:14];

    // Read data trails the strobe by one cycle, so tag it with the word it answers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q   <= 1'b0;
            word_q <= '0;
        end else begin
            rd_q   <= bus.ram_rd;
            word_q <= word;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_q) begin
            case (word_q)
                WORD_CODE: w_code <= bus.ram_data[CODE_IN_W-1:0];
                WORD_X:    w_x    <= bus.ram_data[POS_W-1:0];
                WORD_Y:    w_y    <= bus.ram_data[POS_W-1:0];
                default:   w_attr <= bus.ram_data[9:0];
            endcase
        end
    end

    // Outputs are registered, so each transition also loads the next state's strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            entry             <= '0;
            word              <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            bus.ram_rd        <= 1'b0;
            bus.code_req      <= 1'b0;
            bus.code_original <= '0;
            desc_reg          <= '0;
        end else begin
            done         <= 1'b0;
            bus.code_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= READ;
                        entry      <= '0;
                        word       <= '0;
                        busy       <= 1'b1;
                        bus.ram_rd <= 1'b1;
                    end
                end
                READ: begin
                    word <= word + 2'd1;
                    if (word == WORD_ATTR) begin
                        if (entry_empty && entry == LAST_ENTRY) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            bus.ram_rd <= 1'b0;
                        end else if (entry_empty) begin
                            entry <= entry + 10'd1;
                        end else begin
                            state             <= BANK;
                            bus.ram_rd        <= 1'b0;
                            bus.code_req      <= 1'b1;
                            bus.code_original <= w_code;
                        end
                    end
                end
                BANK: begin
                    state <= CAPT;
                end
                CAPT: begin
                    desc_reg <= '{code:  bus.code_modified,
                                  x:     w_x,
                                  y:     w_y,
                                  color: w_attr[7:0],
                                  flipx: w_attr[8],
                                  flipy: w_attr[9]};
                    state    <= PUSH;
                end
                PUSH: begin
                    if (!fifo_full) begin
                        if (entry == LAST_ENTRY) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state      <= READ;
                            entry      <= entry + 10'd1;
                            word       <= '0;
                            bus.ram_rd <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    f2_sprite_desc_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data (desc_reg),
        .full    (fifo_full),
        .rd_en   (bus.desc_ready),
        .rd_data (head),
        .empty   (fifo_empty)
    );

    assign bus.desc_valid = ~fifo_empty;
    assign bus.desc_code  = head.code;
    assign bus.desc_x     = head.x;
    assign bus.desc_y     = head.y;
    assign bus.desc_color = head.color;
    assign bus.desc_flipx = head.flipx;
    assign bus.desc_flipy = head.flipy;

endmodule

// File: doc/f2_sprite_scan.md
F2_SPRITE_SCAN -- requirements
Module: f2_sprite_scan

Interface
REQ-001 Parameter NUM_ENTRIES, default 1024, sets the number of sprite RAM entries walked per scan (power of two, at most 1024).
REQ-002 Parameter FIFO_DEPTH, default 4, sets the descriptor FIFO depth (power of two, at least 2).
REQ-003 clk  input  1  clock; all logic is rising-edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse that begins a scan of entries 0..NUM_ENTRIES-1.
REQ-006 busy  output  1  high from the cycle after an accepted start until done.
REQ-007 done  output  1  one-cycle pulse once the last entry has been pushed to the FIFO or skipped.
REQ-008 ram_rd  output  1  sprite RAM read strobe.
REQ-009 ram_addr  output  12  {entry[9:0], word[1:0]}.
REQ-010 ram_data  input  16  read data, valid exactly 1 cycle after ram_rd.
REQ-011 code_req  output  1  request strobe to the code-banking stage.
REQ-012 code_original  output  14  unbanked tile code, valid while code_req is high.
REQ-013 code_modified  input  20  banked code, valid the cycle after code_req.
REQ-014 desc_valid / desc_ready  output / input  1 / 1  descriptor handshake; a transfer occurs on valid&ready.
REQ-015 desc_code 20, desc_x 12, desc_y 12, desc_color 8, desc_flipx 1, desc_flipy 1  outputs  FIFO head descriptor.

Function
REQ-016 Entry word layout: w0[13:0]=code; w1[11:0]=x; w2[11:0]=y; w3[7:0]=color, w3[8]=flipx, w3[9]=flipy; all other bits ignored.
REQ-017 FSM states: IDLE, READ, BANK, CAPT, PUSH, DONE.
REQ-018 IDLE: on start, entry=0 and go to READ; start is ignored in every other state.
REQ-019 READ: 4 consecutive cycles with ram_rd=1 and word=0..3; each word is latched one cycle later; then go to BANK.
REQ-020 BANK: one cycle with code_req=1 and code_original=w0[13:0]; then go to CAPT.
REQ-021 CAPT: latch code_modified and assemble the descriptor; then go to PUSH.
REQ-022 PUSH: write to the FIFO when it is not full, otherwise stall in PUSH; after the write go to READ with entry+1, or to DONE if entry==NUM_ENTRIES-1.
REQ-023 DONE: assert done for one cycle, then go to IDLE; done does not wait for the FIFO to drain.
REQ-024 With no stall, each entry takes 7 cycles from its first ram_rd to its FIFO write.
REQ-025 The FIFO is first-word fall-through: desc_valid=~empty, and desc_* always show the head entry.
REQ-026 A FIFO write and a read in the same cycle when full: only the read occurs, and the write retries next cycle.
REQ-027 A write and a read in the same cycle when not full: both occur and the count is unchanged.
REQ-028 ram_rd and code_req are 0 outside the READ and BANK states respectively.

Reset
REQ-029 Reset state: IDLE, FIFO empty, busy=0, done=0, ram_rd=0, ram_addr=0, code_req=0, code_original=0, desc_valid=0.
REQ-030 Reset asserted mid-scan aborts the scan immediately; done is not pulsed and any queued descriptors are discarded.

Configuration
REQ-031 With F2_SPRITE_EMPTY_SKIP_EN defined, an entry with w0[13:0]==0 skips BANK, CAPT and PUSH and advances directly (or to DONE if last); no descriptor is produced.
REQ-032 With F2_SPRITE_EMPTY_SKIP_EN undefined, every entry produces a descriptor.

Structure
REQ-033 Package f2_sprite_pkg holds the sprite_desc_t struct {code, x, y, color, flipx, flipy}, the FSM state enum and the word-index constants.
REQ-034 The FIFO is sub-module f2_sprite_desc_fifo, parameterised by FIFO_DEPTH, storing sprite_desc_t.

Verification
REQ-035 Entry 0 = {0x1234, 0x050, 0x0A0, 0x2C5}, banking returns 0xABCDE, desc_ready=1 -> one descriptor {0xABCDE, 0x050, 0x0A0, color 0xC5, flipx 0, flipy 1}, and code_original=0x1234 during code_req.
REQ-036 NUM_ENTRIES=8, desc_ready=1 -> 8 descriptors in order; done pulses exactly once, 56 cycles after the first ram_rd, plus up to 2 cycles of start/DONE overhead.
REQ-037 desc_ready=0, NUM_ENTRIES=8, FIFO_DEPTH=4 -> 4 descriptors queued and the FSM stalls in PUSH; raising desc_ready releases the rest with no loss or duplication.
REQ-038 Reset asserted during entry 3 -> all outputs reach their reset values next cycle; a new start rescans from entry 0.
REQ-039 With F2_SPRITE_EMPTY_SKIP_EN, entries 1 and 2 have code 0 -> descriptors only for entries 0 and 3 onward, and no code_req for entries 1 and 2.
REQ-040 start pulsed while busy -> ignored, and the scan order and done timing are unchanged.
